// File: rtl/processing_mem_port2_arbiter.sv
// Two-master arbiter for processing-memory port s2: round-robin per transfer with an optional
// lock for atomic sequences, and a fixed-latency tracker that routes read data back to its owner.
module processing_mem_port2_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 16,
    parameter int BE_W         = 2,
    parameter int READ_LATENCY = 1,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [BE_W-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED0  = 2'd1,
        ST_LOCKED1  = 2'd2
    } lock_state_t;

    lock_state_t             r_state;
    lock_state_t             w_state_nxt;
    logic [CNT_W-1:0]        r_idle_cnt;
    logic                    r_last_grant;
    logic [READ_LATENCY-1:0] r_rd_valid;
    logic [READ_LATENCY-1:0] r_rd_owner;

    logic w_req0, w_req1;
    logic w_grant0, w_grant1;
    logic w_accept, w_sel_read, w_sel_write, w_accept_rd;
    logic w_locked, w_owner_req, w_timeout, w_idle_clr;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_LOCKED0: w_grant0 = w_req0;
                ST_LOCKED1: w_grant1 = w_req1;
                default: begin
                    if (w_req0 && w_req1) begin
                        // Contention goes to whichever master did not win the last transfer.
                        w_grant0 = r_last_grant;
                        w_grant1 = ~r_last_grant;
                    end else begin
                        w_grant0 = w_req0;
                        w_grant1 = w_req1;
                    end
                end
            endcase
        end
    end

    assign w_accept    = w_grant0 | w_grant1;
    assign w_sel_read  = w_grant1 ? m1_read  : m0_read;
    assign w_sel_write = w_grant1 ? m1_write : m0_write;
    // Read+write together is a protocol error: it goes out as a write and is never tracked as a read.
    assign w_accept_rd = w_accept & w_sel_read & ~w_sel_write;

    assign mem_chipselect = w_accept;
    assign mem_write      = w_accept & w_sel_write;
    assign mem_address    = w_accept ? (w_grant1 ? m1_address    : m0_address)    : '0;
    assign mem_writedata  = w_accept ? (w_grant1 ? m1_writedata  : m0_writedata)  : '0;
    assign mem_byteenable = w_accept ? (w_grant1 ? m1_byteenable : m0_byteenable) : '0;

    assign m0_waitrequest = reset | (w_req0 & ~w_grant0);
    assign m1_waitrequest = reset | (w_req1 & ~w_grant1);

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = ~reset & r_rd_valid[READ_LATENCY-1] & ~r_rd_owner[READ_LATENCY-1];
    assign m1_readdatavalid = ~reset & r_rd_valid[READ_LATENCY-1] &  r_rd_owner[READ_LATENCY-1];

    assign w_locked    = (r_state != ST_UNLOCKED);
    assign w_owner_req = (r_state == ST_LOCKED0) ? w_req0 :
                         (r_state == ST_LOCKED1) ? w_req1 : 1'b0;
    // Unlock on the cycle whose idle count would become LOCK_TIMEOUT-1.
    assign w_timeout   = w_locked & ~w_owner_req & (r_idle_cnt == CNT_W'(LOCK_TIMEOUT - 2));
    assign w_idle_clr  = ~w_locked | w_owner_req | (w_state_nxt != r_state);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_grant0 && m0_lock)      w_state_nxt = ST_LOCKED0;
                else if (w_grant1 && m1_lock) w_state_nxt = ST_LOCKED1;
            end
            ST_LOCKED0: if ((w_grant0 && !m0_lock) || w_timeout) w_state_nxt = ST_UNLOCKED;
            ST_LOCKED1: if ((w_grant1 && !m1_lock) || w_timeout) w_state_nxt = ST_UNLOCKED;
            default:    w_state_nxt = ST_UNLOCKED;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_UNLOCKED;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle_cnt   <= '0;
            r_last_grant <= 1'b1;
            // NOTE: the read tracker is reset (unlike a data memory) so in-flight valids are dropped.
            r_rd_valid   <= '0;
            r_rd_owner   <= '0;
        end else begin
            r_idle_cnt <= w_idle_clr ? '0 : r_idle_cnt + 1'b1;
            if (w_accept) r_last_grant <= w_grant1;
            r_rd_valid[0] <= w_accept_rd;
            r_rd_owner[0] <= w_grant1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rd_valid[i] <= r_rd_valid[i-1];
                r_rd_owner[i] <= r_rd_owner[i-1];
            end
        end
    end

endmodule

// File: tb/tb_processing_mem_port2_arbiter.sv
// Directed bench for processing_mem_port2_arbiter: cycle table plus hand-written lock/reset/stream
// sequences, against a small s2 memory model with one-cycle read latency.
module tb_processing_mem_port2_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] m0_address, m1_address;
    logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [15:0] m0_writedata, m1_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [15:0] m0_readdata, m1_readdata;
    logic [13:0] mem_address;
    logic        mem_chipselect, mem_write;
    logic [15:0] mem_writedata;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem_readdata = 16'h0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    processing_mem_port2_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata)
    );

    // s2 model: unwritten words read as a fixed address pattern; reads return one cycle later.
    bit [15:0] mem_model [16384];
    bit        mem_written [16384];

    function automatic logic [15:0] fill_pattern(input logic [13:0] a);
        return 16'h5A5A ^ {2'b00, a};
    endfunction

    function automatic logic [15:0] merge_word(input bit wr, input logic [15:0] old, input logic [13:0] a,
                                               input logic [15:0] wd, input logic [1:0] be);
        logic [15:0] w;
        w = wr ? old : fill_pattern(a);
        if (be[0]) w[7:0]  = wd[7:0];
        if (be[1]) w[15:8] = wd[15:8];
        return w;
    endfunction

    always @(posedge clk) begin
        if (mem_chipselect && mem_write) begin
            mem_model[mem_address]   <= merge_word(mem_written[mem_address], mem_model[mem_address],
                                                   mem_address, mem_writedata, mem_byteenable);
            mem_written[mem_address] <= 1'b1;
        end
        if (mem_chipselect && !mem_write)
            mem_readdata <= mem_written[mem_address] ? mem_model[mem_address] : fill_pattern(mem_address);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        r0, w0, l0; logic [13:0] a0; logic [15:0] d0; logic [1:0] b0;
        logic        r1, w1, l1; logic [13:0] a1; logic [15:0] d1; logic [1:0] b1;
        logic        ewr0, ewr1, ecs, ewe; logic [13:0] eaddr; logic [15:0] edata; logic [1:0] ebe;
        logic        erv0, erv1; logic [15:0] erdata;
    } vec_t;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    vec_t vecs [13];

    task automatic drive_idle();
        reset = 1'b0;
        m0_read = 1'b0; m0_write = 1'b0; m0_lock = 1'b0;
        m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_lock = 1'b0;
        m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst;
        m0_read = v.r0; m0_write = v.w0; m0_lock = v.l0;
        m0_address = v.a0; m0_writedata = v.d0; m0_byteenable = v.b0;
        m1_read = v.r1; m1_write = v.w1; m1_lock = v.l1;
        m1_address = v.a1; m1_writedata = v.d1; m1_byteenable = v.b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int i0, i1, cyc, owner, item, waited;
        logic got, acc0, acc1;
        logic [13:0] ea;
        logic [15:0] ed;
        logic [1:0]  eb;

        // Field order: rst | r0 w0 l0 a0 d0 b0 | r1 w1 l1 a1 d1 b1 | wr0 wr1 cs we addr wdata be | rv0 rv1 rdata
        vecs[0]  = '{Y, Y,N,N,14'h3A97,16'h0000,2'b11, N,Y,N,14'h0555,16'h1234,2'b11, Y,Y,N,N,14'h0000,16'h0000,2'b00, N,N,16'h0000};
        vecs[1]  = '{Y, N,N,N,14'h0000,16'h0000,2'b00, N,N,N,14'h0000,16'h0000,2'b00, Y,Y,N,N,14'h0000,16'h0000,2'b00, N,N,16'h0000};
        vecs[2]  = '{N, Y,N,N,14'h0010,16'h0000,2'b11, Y,N,N,14'h0020,16'h0000,2'b11, N,Y,Y,N,14'h0010,16'h0000,2'b11, N,N,16'h0000};
        vecs[3]  = '{N, N,N,N,14'h0000,16'h0000,2'b00, Y,N,N,14'h0020,16'h0000,2'b11, N,N,Y,N,14'h0020,16'h0000,2'b11, Y,N,16'h5A4A};
        vecs[4]  = '{N, N,N,N,14'h0000,16'h0000,2'b00, N,N,N,14'h0000,16'h0000,2'b00, N,N,N,N,14'h0000,16'h0000,2'b00, N,Y,16'h5A7A};
        vecs[5]  = '{N, N,N,N,14'h0000,16'h0000,2'b00, Y,Y,N,14'h0100,16'hBEEF,2'b11, N,N,Y,Y,14'h0100,16'hBEEF,2'b11, N,N,16'h0000};
        vecs[6]  = '{N, Y,N,N,14'h0100,16'h0000,2'b11, N,N,N,14'h0000,16'h0000,2'b00, N,N,Y,N,14'h0100,16'h0000,2'b11, N,N,16'h0000};
        vecs[7]  = '{N, N,N,N,14'h0000,16'h0000,2'b00, N,N,N,14'h0000,16'h0000,2'b00, N,N,N,N,14'h0000,16'h0000,2'b00, Y,N,16'hBEEF};
        vecs[8]  = '{N, N,Y,N,14'h0200,16'hAAAA,2'b01, N,Y,Y,14'h0300,16'h1111,2'b11, Y,N,Y,Y,14'h0300,16'h1111,2'b11, N,N,16'h0000};
        vecs[9]  = '{N, N,Y,N,14'h0200,16'hAAAA,2'b01, N,Y,Y,14'h0301,16'h2222,2'b11, Y,N,Y,Y,14'h0301,16'h2222,2'b11, N,N,16'h0000};
        vecs[10] = '{N, N,Y,N,14'h0200,16'hAAAA,2'b01, N,Y,N,14'h0302,16'h3333,2'b10, Y,N,Y,Y,14'h0302,16'h3333,2'b10, N,N,16'h0000};
        vecs[11] = '{N, N,Y,N,14'h0200,16'hAAAA,2'b01, N,N,N,14'h0000,16'h0000,2'b00, N,N,Y,Y,14'h0200,16'hAAAA,2'b01, N,N,16'h0000};
        vecs[12] = '{N, N,N,N,14'h0000,16'h0000,2'b00, N,N,N,14'h0000,16'h0000,2'b00, N,N,N,N,14'h0000,16'h0000,2'b00, N,N,16'h0000};

        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset behaviour, simultaneous reads, read+write error, and m1 lock sequence.
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d_ctrl", i),
                  64'({m0_waitrequest, m1_waitrequest, mem_chipselect, mem_write, m0_readdatavalid, m1_readdatavalid}),
                  64'({vecs[i].ewr0, vecs[i].ewr1, vecs[i].ecs, vecs[i].ewe, vecs[i].erv0, vecs[i].erv1}));
            if (vecs[i].ecs || vecs[i].rst)
                check($sformatf("vec%0d_bus", i), 64'({mem_address, mem_writedata, mem_byteenable}),
                      64'({vecs[i].eaddr, vecs[i].edata, vecs[i].ebe}));
            if (vecs[i].erv0) check($sformatf("vec%0d_m0_rdata", i), 64'(m0_readdata), 64'(vecs[i].erdata));
            if (vecs[i].erv1) check($sformatf("vec%0d_m1_rdata", i), 64'(m1_readdata), 64'(vecs[i].erdata));
            next_cycle();
        end

        // Reset one cycle after an accepted read drops its readdatavalid.
        drive_idle();
        m0_read = 1'b1; m0_address = 14'h3A97; m0_byteenable = 2'b11;
        @(negedge clk);
        check("t5_read_accept", 64'({m0_waitrequest, mem_chipselect, mem_write}), 64'(3'b010));
        next_cycle();
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        check("t5_in_reset", 64'({m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest, mem_chipselect}),
              64'(5'b00110));
        next_cycle();
        reset = 1'b0;
        m0_read = 1'b1; m0_address = 14'h0010; m0_byteenable = 2'b11;
        m1_read = 1'b1; m1_address = 14'h0020; m1_byteenable = 2'b11;
        @(negedge clk);
        check("t5_post_reset_first", 64'({m0_readdatavalid, m0_waitrequest, m1_waitrequest, mem_address}),
              64'({1'b0, 1'b0, 1'b1, 14'h0010}));
        next_cycle();
        m0_read = 1'b0;
        @(negedge clk);
        check("t5_post_reset_second", 64'({m0_readdatavalid, m1_readdatavalid, m1_waitrequest, mem_address}),
              64'({1'b1, 1'b0, 1'b0, 14'h0020}));
        check("t5_m0_rdata", 64'(m0_readdata), 64'(16'h5A4A));
        next_cycle();
        drive_idle();
        @(negedge clk);
        check("t5_m1_valid", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(2'b01));
        next_cycle();

        // Both masters stream 8 writes: expect m0,m1,m0,... one accepted write per cycle.
        i0 = 0; i1 = 0; cyc = 0;
        while ((i0 < 8 || i1 < 8) && cyc < 24) begin
            m0_write = (i0 < 8); m0_address = 14'h1000 + 14'(i0);
            m0_writedata = 16'hA000 + 16'(i0); m0_byteenable = i0[0] ? 2'b01 : 2'b11;
            m1_write = (i1 < 8); m1_address = 14'h2000 + 14'(i1);
            m1_writedata = 16'hB000 + 16'(i1); m1_byteenable = i1[0] ? 2'b10 : 2'b11;
            @(negedge clk);
            owner = cyc % 2;
            item  = cyc / 2;
            ea = (owner == 1) ? 14'h2000 + 14'(item) : 14'h1000 + 14'(item);
            ed = (owner == 1) ? 16'hB000 + 16'(item) : 16'hA000 + 16'(item);
            eb = (owner == 1) ? ((item % 2 == 1) ? 2'b10 : 2'b11) : ((item % 2 == 1) ? 2'b01 : 2'b11);
            check($sformatf("t2_cycle%0d", cyc),
                  64'({mem_chipselect, mem_write, m0_waitrequest, m1_waitrequest, mem_address, mem_writedata, mem_byteenable}),
                  64'({1'b1, 1'b1, (owner == 1) && (cyc < 15), owner == 0, ea, ed, eb}));
            acc0 = m0_write && !m0_waitrequest;
            acc1 = m1_write && !m1_waitrequest;
            next_cycle();
            if (acc0) i0++;
            if (acc1) i1++;
            cyc++;
        end
        check("t2_total_cycles", 64'(cyc), 64'(16));
        drive_idle();

        // m0 locks then idles; m1 must wait exactly LOCK_TIMEOUT cycles.
        m0_write = 1'b1; m0_lock = 1'b1; m0_address = 14'h0400; m0_writedata = 16'h4444; m0_byteenable = 2'b11;
        @(negedge clk);
        check("t4_lock_accept", 64'({m0_waitrequest, mem_chipselect, mem_write}), 64'(3'b011));
        next_cycle();
        drive_idle();
        m1_write = 1'b1; m1_address = 14'h0500; m1_writedata = 16'h5555; m1_byteenable = 2'b11;
        waited = 0; got = 1'b0;
        while (!got && waited < 100) begin
            waited++;
            @(negedge clk);
            if (!m1_waitrequest) got = 1'b1;
            next_cycle();
        end
        check("t4_m1_grant_cycle", 64'(waited), 64'(64));
        drive_idle();
        @(negedge clk);
        check("t4_idle_after", 64'({m0_waitrequest, m1_waitrequest, mem_chipselect}), 64'(3'b000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
